// File: rtl/word_uart_tx.sv
// word_uart_tx: 8N1 LSB-first word framer/transmitter (STX, letters, XOR sum).
// clk/Rst(sync, high); send+word_in request; tx line, busy, done pulse.
module word_uart_tx #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int NUM_CHARS    = 5
) (
  input  logic                   clk,
  input  logic                   Rst,
  input  logic                   send,
  input  logic [8*NUM_CHARS-1:0] word_in,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = (CLKS_PER_BIT > 1) ?
                      $clog2(CLKS_PER_BIT) : 1;
  localparam int NB = NUM_CHARS + 2;
  localparam int BW = $clog2(NB);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                 state_q, state_n;
  logic [CW-1:0]          baud_q, baud_n;
  logic [2:0]             bit_q, bit_n;
  logic [BW-1:0]          byte_q, byte_n;
  logic [8*NUM_CHARS-1:0] word_q;
  logic [7:0]             frame_b [NB];
  logic [7:0]             csum;
  logic [7:0]             cur_byte;
  logic                   bit_end;
  logic                   tx_d, busy_d, done_d;

  // Frame byte table built from the latched word.
  always_comb begin
    csum = '0;
    frame_b[0] = 8'h02;
    for (int i = 0; i < NUM_CHARS; i++) begin
      frame_b[i+1] = word_q[8*(NUM_CHARS-i)-1 -: 8];
      csum = csum ^ word_q[8*(NUM_CHARS-i)-1 -: 8];
    end
    frame_b[NB-1] = csum;
  end

  assign bit_end  = (baud_q == LAST_CNT);
  assign cur_byte = frame_b[byte_n];

  // State and output registers.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      byte_q  <= byte_n;
      if (state_q == IDLE && send)
        word_q <= word_in;
      tx      <= tx_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    byte_n  = byte_q;
    unique case (state_q)
      IDLE: begin
        if (send) begin
          state_n = START;
          baud_n  = '0;
          bit_n   = '0;
          byte_n  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = '0;
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_q == 3'd7)
            state_n = STOP;
          else
            bit_n = bit_q + 1'b1;
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (byte_q < LAST_BYTE) begin
            byte_n  = byte_q + 1'b1;
            state_n = START;
          end else begin
            byte_n  = '0;
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs decoded from the next state, then registered.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_n != IDLE);
    done_d = (state_q == STOP) && (state_n == IDLE);
    unique case (state_n)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_n];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_word_uart_tx.sv
// tb_word_uart_tx: table, directed and random frames vs a waveform model.
// Drives word_uart_tx with CLKS_PER_BIT=4, NUM_CHARS=5.
module tb_word_uart_tx;

  localparam int C   = 4;
  localparam int NC  = 5;
  localparam int NBY = NC + 2;
  localparam int N   = NBY * 10 * C;

  localparam logic [39:0] APPLE = 40'h4150504C45;

  logic            tb_clk = 1'b0;
  logic            Rst;
  logic            send;
  logic [8*NC-1:0] word_in;
  logic            tx, busy, done;

  int tests = 0;
  int fails = 0;

  logic cap_tx   [N];
  bit   exp_wave [N];
  int   busy_bad, done_cnt;

  typedef struct {
    logic [39:0] word;
    logic [7:0]  csum;
    int          mode;
  } vec_t;

  vec_t vecs [8];

  always #5 tb_clk = ~tb_clk;

  word_uart_tx #(
    .CLKS_PER_BIT(C),
    .NUM_CHARS(NC)
  ) dut (
    .clk(tb_clk),
    .Rst(Rst),
    .send(send),
    .word_in(word_in),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] xsum(input logic [39:0] w);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < NC; i++)
      s = s ^ w[8*i +: 8];
    return s;
  endfunction

  // Reference line waveform: each byte is start, 8 LSB-first bits, stop.
  task automatic build_exp(input logic [39:0] w);
    logic [7:0] b [NBY];
    bit v;
    b[0] = 8'h02;
    for (int i = 0; i < NC; i++)
      b[i+1] = w[39-8*i -: 8];
    b[NBY-1] = xsum(w);
    for (int n = 0; n < NBY; n++)
      for (int p = 0; p < 10; p++) begin
        if (p == 0) v = 1'b0;
        else if (p == 9) v = 1'b1;
        else v = b[n][p-1];
        for (int c = 0; c < C; c++)
          exp_wave[(n*10+p)*C+c] = v;
      end
  endtask

  // mode 0 plain, 1 send pulse while busy, 2 word_in changed at k+2,
  // 3 send held high (ends in the done cycle with send still 1).
  task automatic send_frame(input logic [39:0] w, input int mode);
    send = 1'b1;
    word_in = w;
    tick();
    busy_bad = 0;
    done_cnt = 0;
    for (int i = 0; i < N; i++) begin
      cap_tx[i] = tx;
      if (busy !== 1'b1) busy_bad++;
      if (done !== 1'b0) done_cnt++;
      if (mode != 3) send = 1'b0;
      if (mode == 1 && i == 99) begin
        send = 1'b1;
        word_in = 40'h5A5A5A5A5A;
      end
      if (mode == 2 && i == 1)
        word_in = 40'h48454C4C4F;
      tick();
    end
    chk("busy_window", busy_bad, 0);
    chk("done_early", done_cnt, 0);
    chk("done_pulse", done, 1);
    chk("busy_off", busy, 0);
    chk("tx_idle_done", tx, 1);
    if (mode != 3) begin
      send = 1'b0;
      tick();
      chk("done_once", done, 0);
      chk("tx_idle", tx, 1);
    end
    if (mode == 1) begin
      int bad;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
        if (busy !== 1'b0 || done !== 1'b0 || tx !== 1'b1) bad++;
        tick();
      end
      chk("lockout_noqueue", bad, 0);
    end
  endtask

  task automatic check_frame(input logic [39:0] w,
                             input logic [7:0] csum_exp,
                             input string nm);
    int mm;
    int frm;
    logic [7:0] d, e;
    build_exp(w);
    mm = 0;
    for (int i = 0; i < N; i++)
      if (cap_tx[i] !== exp_wave[i]) mm++;
    chk({nm, "_wave"}, mm, 0);
    frm = 0;
    for (int n = 0; n < NBY; n++) begin
      if (cap_tx[(n*10)*C + C/2] !== 1'b0) frm++;
      if (cap_tx[(n*10+9)*C + C/2] !== 1'b1) frm++;
      for (int j = 0; j < 8; j++)
        d[j] = cap_tx[(n*10+1+j)*C + C/2];
      if (n == 0) e = 8'h02;
      else if (n == NBY-1) e = csum_exp;
      else e = w[8*(NC-n+1)-1 -: 8];
      chk($sformatf("%s_byte%0d", nm, n), d, e);
    end
    chk({nm, "_framing"}, frm, 0);
  endtask

  initial begin
    vecs[0] = '{APPLE,         8'h48, 0};
    vecs[1] = '{APPLE,         8'h48, 1};
    vecs[2] = '{APPLE,         8'h48, 2};
    vecs[3] = '{40'h0,         8'h00, 0};
    vecs[4] = '{40'h48454C4C4F, 8'h42, 0};
    vecs[5] = '{40'h5A5A5A5A5A, 8'h5A, 0};
    vecs[6] = '{40'h4142434445, 8'h41, 0};
    vecs[7] = '{40'hFFFFFFFFFF, 8'hFF, 0};

    Rst = 1'b1;
    send = 1'b0;
    word_in = '0;
    tick();
    tick();
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    Rst = 1'b0;
    tick();

    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].word, vecs[v].mode);
      check_frame(vecs[v].word, vecs[v].csum,
                  $sformatf("vec%0d", v));
    end

    send_frame(APPLE, 3);
    check_frame(APPLE, 8'h48, "b2b_first");
    send_frame(APPLE, 0);
    check_frame(APPLE, 8'h48, "b2b_second");

    for (int r = 0; r < 6; r++) begin
      logic [63:0] t;
      logic [39:0] w;
      t = {$urandom(), $urandom()};
      w = t[39:0];
      repeat ($urandom_range(0, 5)) tick();
      send_frame(w, 0);
      check_frame(w, xsum(w), $sformatf("rnd%0d", r));
    end

    begin
      int bad;
      send = 1'b1;
      word_in = APPLE;
      tick();
      send = 1'b0;
      repeat (12) tick();
      chk("pre_rst_busy", busy, 1);
      Rst = 1'b1;
      tick();
      chk("midrst_tx", tx, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      Rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 400; i++) begin
        tick();
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      chk("midrst_quiet", bad, 0);
    end

    send_frame(40'h4142434445, 0);
    check_frame(40'h4142434445, 8'h41, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/word_uart_tx.md
Name: word_uart_tx

Overview:
- Host-side serial transmitter for the wireless hangman link.
- When the host submits a word, this block latches it, frames it, and shifts it out over the UART/radio line to the player board. It is the sending end of the link whose receiver sits on the player side.
- Frame is 8N1, LSB first: STX byte (0x02), NUM_CHARS ASCII letters (leftmost first), then XOR checksum byte.

Parameters:
- CLKS_PER_BIT, 1250, clk cycles per UART bit (12 MHz / 9600 baud).
- NUM_CHARS, 5, letters per word frame.

Ports:
- clk  input  1  system clock.
- Rst  input  1  synchronous, active-high reset.
- send  input  1  request to transmit word_in; sampled on posedge clk.
- word_in  input  8*NUM_CHARS  ASCII word; [8*NUM_CHARS-1 -: 8] is the first letter.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in flight.
- done  output  1  one-cycle pulse after the final stop bit.

Behaviour:
- Reset (Rst=1 at posedge): next cycle tx=1, busy=0, done=0. State=IDLE, all counters 0, shift/word registers cleared.
- Reset mid-frame: the frame is aborted immediately (tx=1 next cycle), no done pulse, nothing resumes after reset release.
- State machine:
  - IDLE: on send=1 at edge k, latch word_in, load byte_idx=0, go START. Otherwise hold tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go DATA with bit_idx=0.
  - DATA: tx=current_byte[bit_idx], each bit for CLKS_PER_BIT cycles. After bit 7, go STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte_idx < NUM_CHARS+1: increment byte_idx, go START (no idle gap between bytes);
    - otherwise go IDLE.
- Byte sequence by byte_idx:
  - 0 = 0x02;
  - 1..NUM_CHARS = letters, first letter first;
  - NUM_CHARS+1 = checksum, the XOR of all letter bytes (STX excluded).
- Checksum is computed from the latched word, combinationally or incrementally. The value sent must be the same either way.
- Outputs are registered:
  - busy and tx change in cycle k+1 after acceptance at edge k;
  - the frame occupies exactly (NUM_CHARS+2)*10*CLKS_PER_BIT cycles, k+1 through k+N;
  - in cycle k+N+1, busy=0 and done=1 for exactly one cycle.
- send while busy=1 is ignored, with no queuing. send held high continuously re-triggers only when the block is back in IDLE.
- send=1 during the done cycle is accepted. The next frame's start bit begins in the following cycle.
- word_in changes after acceptance have no effect on the frame in flight.
- Baud counter counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). It wraps to 0 at each bit boundary, and bit timing has no cumulative drift.
- No combinational path from send to tx.

Test Plan:
- Reset: Rst=1 for 2 cycles mid-idle -> tx=1, busy=0, done=0. Rst=1 while in DATA -> tx=1 the next cycle, busy=0, no done pulse ever.
- APPLE frame (CLKS_PER_BIT=4): word_in=0x4150504C45, send pulse at edge k.
  - Expected: tx decodes as bytes 0x02,0x41,0x50,0x50,0x4C,0x45,0x48 (8N1, LSB first, each bit exactly 4 cycles).
  - busy high for cycles k+1..k+280; done=1 only at k+281.
- Busy lockout: during the APPLE frame, pulse send with word_in=0x5A5A5A5A5A at cycle k+100 -> frame unchanged, only one done pulse.
- Back-to-back: hold send=1 continuously with APPLE -> second start bit begins at k+282; second frame identical to the first.
- Input stability: change word_in to "HELLO" in cycle k+2 -> transmitted letters remain A,P,P,L,E and checksum remains 0x48.
- Checksum edge case: word_in=0x0000000000 -> bytes 0x02, five 0x00, checksum 0x00. Line stays low for each 8-bit data span, and all start/stop bits are correct.
